// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and default width
// for the multi-cycle ALU slice.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_ROR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_logic_unit.sv
// alu_logic_unit: combinational FWD/ADD/AND/OR datapath
// used for the single-cycle ops of alu_seq.
module alu_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Opcode decode; anything outside the four logic ops yields zero,
   // which is also the MUL result when the multiplier is absent.
   always_comb begin
      y = '0;
      case (sel)
         OP_FWD:  y = b;
         OP_ADD:  y = a + b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with START/BUSY/DONE handshake.
// Define ALU_MULT_EN to build the iterative shift-add multiplier.
module alu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = ALU_WIDTH,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_nx;
   logic [WIDTH-1:0] lu_y;
   logic [WIDTH-1:0] cap_y;
   logic [SHW-1:0]   n;
   logic             is_shift;

   assign n        = DATA2[SHW-1:0];
   assign is_shift = SELECT inside {OP_SHL, OP_SHR, OP_ROR};
   // A zero-length shift completes at once with the source unchanged.
   assign cap_y    = is_shift ? DATA1 : lu_y;

   alu_logic_unit #(.WIDTH(WIDTH)) u_lu (
      .sel (SELECT),
      .a   (DATA1),
      .b   (DATA2),
      .y   (lu_y)
   );

   // One bit position of the captured shift/rotate per cycle.
   always_comb begin
      sh_nx = sh_q;
      case (op_q)
         OP_SHL:  sh_nx = {sh_q[WIDTH-2:0], 1'b0};
         OP_SHR:  sh_nx = {1'b0, sh_q[WIDTH-1:1]};
         default: sh_nx = {sh_q[0], sh_q[WIDTH-1:1]};
      endcase
   end

`ifdef ALU_MULT_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             is_mul;

   assign is_mul = (SELECT == OP_MUL);

   // Shift-add step: only the low WIDTH product bits are kept.
   assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

   // Control FSM with registered RESULT/ZERO/BUSY/DONE.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= ST_IDLE;
         op_q   <= OP_FWD;
         cnt    <= '0;
         sh_q   <= '0;
         RESULT <= '0;
         ZERO   <= 1'b1;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
`ifdef ALU_MULT_EN
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  op_q <= SELECT;
                  if (is_shift && n != '0) begin
                     sh_q  <= DATA1;
                     cnt   <= CW'(n);
                     BUSY  <= 1'b1;
                     state <= ST_SHIFT;
                  end
`ifdef ALU_MULT_EN
                  else if (is_mul) begin
                     acc    <= '0;
                     mcand  <= DATA1;
                     mplier <= DATA2;
                     cnt    <= CW'(WIDTH);
                     BUSY   <= 1'b1;
                     state  <= ST_MUL;
                  end
`endif
                  else begin
                     RESULT <= cap_y;
                     ZERO   <= (cap_y == '0);
                     DONE   <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (cnt == CW'(1)) begin
                  RESULT <= sh_nx;
                  ZERO   <= (sh_nx == '0);
                  DONE   <= 1'b1;
                  BUSY   <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  sh_q <= sh_nx;
                  cnt  <= cnt - CW'(1);
               end
            end
`ifdef ALU_MULT_EN
            ST_MUL: begin
               acc    <= acc_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == CW'(1)) begin
                  RESULT <= acc_nx;
                  ZERO   <= (acc_nx == '0);
                  DONE   <= 1'b1;
                  BUSY   <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`endif
            default: begin
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a queued scoreboard
// and an independent DONE monitor for alu_seq (WIDTH=8).
module tb_alu_seq;

   typedef struct {
      logic [7:0] r;
      logic       z;
      int         c;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [2:0] SELECT = 3'b000;
   logic [7:0] DATA1 = 8'h00;
   logic [7:0] DATA2 = 8'h00;
   logic [7:0] RESULT;
   logic       ZERO;
   logic       BUSY;
   logic       DONE;

   exp_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last = 8'h00;

   alu_seq dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .SELECT (SELECT),
      .DATA1  (DATA1),
      .DATA2  (DATA2),
      .RESULT (RESULT),
      .ZERO   (ZERO),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation on every DONE pulse.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (RESET) begin
            last = 8'h00;
         end else if (DONE) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
               last = RESULT;
            end else begin
               e = sb.pop_front();
               chk("result", RESULT, e.r);
               chk("zero", ZERO, e.z);
               chk("latency", cyc, e.c);
               last = e.r;
            end
         end else begin
            chk("result_hold", RESULT, last);
         end
      end
   end

   task automatic expect_op(input logic [7:0] r, input int lat);
      exp_t e;
      e.r = r;
      e.z = (r == 8'h00);
      e.c = cyc + 1 + lat;
      sb.push_back(e);
   endtask

   task automatic drain(input int exp_busy);
      int b;
      b = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         START = 1'b0;
         DATA1 = 8'($urandom);
         DATA2 = 8'($urandom);
         if (BUSY) b++;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         chk("timeout", sb.size(), 0);
         sb.delete();
      end
      chk("busy_cycles", b, exp_busy);
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] d1,
                        input logic [7:0] d2);
      SELECT = sel;
      DATA1  = d1;
      DATA2  = d2;
      START  = 1'b1;
   endtask

   task automatic run_op(input logic [2:0] sel, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] r,
                         input int lat);
      @(negedge CLK);
      drive(sel, d1, d2);
      expect_op(r, lat);
      drain(lat);
   endtask

   initial begin
      int k;
      @(negedge CLK);
      chk("rst_result", RESULT, 8'h00);
      chk("rst_zero", ZERO, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;

      run_op(3'b001, 8'd200, 8'd100, 8'd44, 0);
      run_op(3'b000, 8'h55, 8'h00, 8'h00, 0);
      run_op(3'b010, 8'hF0, 8'h3C, 8'h30, 0);
      run_op(3'b011, 8'hF0, 8'h0F, 8'hFF, 0);
`ifdef ALU_MULT_EN
      run_op(3'b100, 8'd13, 8'd11, 8'h8F, 8);
      run_op(3'b100, 8'd16, 8'd16, 8'h00, 8);
      run_op(3'b100, 8'd255, 8'd255, 8'h01, 8);
`else
      run_op(3'b011, 8'h01, 8'h00, 8'h01, 0);
      run_op(3'b100, 8'd5, 8'd5, 8'h00, 0);
`endif
      run_op(3'b101, 8'h03, 8'h03, 8'h18, 3);
      run_op(3'b110, 8'h80, 8'h07, 8'h01, 7);
      run_op(3'b111, 8'h81, 8'h01, 8'hC0, 1);
      run_op(3'b111, 8'h81, 8'h04, 8'h18, 4);
      run_op(3'b101, 8'h03, 8'h00, 8'h03, 0);
      run_op(3'b101, 8'h03, 8'hF9, 8'h06, 1);

      // START while busy must be ignored.
      @(negedge CLK);
      drive(3'b110, 8'h80, 8'h07);
      expect_op(8'h01, 7);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      drive(3'b001, 8'd1, 8'd2);
      @(negedge CLK);
      START = 1'b0;
      drain(3);
`ifdef ALU_MULT_EN
      @(negedge CLK);
      drive(3'b100, 8'd13, 8'd11);
      expect_op(8'h8F, 8);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      drive(3'b100, 8'd7, 8'd9);
      @(negedge CLK);
      START = 1'b0;
      drain(4);
`endif

      // Back-to-back: new START in the DONE cycle.
      @(negedge CLK);
      drive(3'b101, 8'h03, 8'h03);
      expect_op(8'h18, 3);
      k = 0;
      do begin
         @(negedge CLK);
         START = 1'b0;
         k++;
      end while (!DONE && k < 20);
      chk("b2b_done_seen", DONE, 1'b1);
      drive(3'b011, 8'hF0, 8'h0F);
      expect_op(8'hFF, 0);
      drain(0);

      // Reset in the middle of a long op aborts it.
      @(negedge CLK);
`ifdef ALU_MULT_EN
      drive(3'b100, 8'd13, 8'd11);
`else
      drive(3'b110, 8'h80, 8'h07);
`endif
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      sb.delete();
      #1;
      chk("abort_result", RESULT, 8'h00);
      chk("abort_zero", ZERO, 1'b1);
      chk("abort_busy", BUSY, 1'b0);
      chk("abort_done", DONE, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (12) @(negedge CLK);
      run_op(3'b001, 8'd1, 8'd1, 8'd2, 0);

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the group's 8-bit single-cycle ALU; sits between the register file and write-back in the CPU datapath.
- Keeps FORWARD/ADD/AND/OR as one-cycle ops.
- Adds iterative shift-left, shift-right, rotate-right and shift-add multiply.
- Uses a START/BUSY/DONE handshake and a registered ZERO flag for branch logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from DATA2[SHW-1:0]; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SHL, 110 SHR, 111 ROR.
- DATA1  input  WIDTH  operand 1; the shift/rotate source.
- DATA2  input  WIDTH  operand 2; for shifts, the amount is DATA2[SHW-1:0] and the upper bits are ignored.
- RESULT  output  WIDTH  registered result, held until the next DONE.
- ZERO  output  1  registered; 1 when RESULT==0, updated with RESULT.
- BUSY  output  1  multi-cycle op in progress.
- DONE  output  1  one-cycle pulse: RESULT/ZERO updated this cycle.

Behaviour:
- Reset (async): RESULT=0, ZERO=1, BUSY=0, DONE=0, FSM=IDLE, internal counters/shadow registers cleared.
- Reset mid-operation aborts the op; no DONE is produced for it.
- FSM states: IDLE, SHIFT, MUL.
- Operand capture: on an edge with START=1 and BUSY=0, DATA1/DATA2/SELECT are captured. Operands may change freely afterwards.
- Single-cycle ops (FWD=DATA2, ADD=DATA1+DATA2 mod 2^WIDTH with carry discarded, AND, OR):
  - RESULT, ZERO and DONE=1 become visible after the capture edge.
  - BUSY never rises; FSM stays IDLE.
  - Subtraction is done upstream by two's-complement negation of DATA2.
- Shifts (SHL logical, SHR logical, ROR rotate), amount n:
  - n=0: treated as single-cycle; RESULT=DATA1.
  - n≥1: IDLE→SHIFT, BUSY=1 after the capture edge. One bit position per cycle, counter loaded with n.
  - Final RESULT, DONE=1 and BUSY=0 all appear on capture edge + n; FSM→IDLE.
- MUL:
  - IDLE→MUL with a shift-add algorithm: accumulator += multiplicand when multiplier LSB=1; multiplicand<<1; multiplier>>1.
  - Runs exactly WIDTH iterations; RESULT = low WIDTH bits of the product.
  - DONE and BUSY=0 on capture edge + WIDTH.
- START while BUSY=1 is ignored, with no queuing.
- START in the cycle where DONE=1 (BUSY already 0) is accepted: back-to-back ops are allowed.
- DONE is exactly one cycle wide. RESULT/ZERO never change except with DONE or RESET.
- Unknown opcodes do not exist; the 3-bit space is fully decoded.

Optional Feature:
- Macro: ALU_MULT_EN.
- Defined: SELECT=100 performs the multi-cycle MUL described above.
- Undefined: the multiplier datapath is not synthesised. SELECT=100 completes as a single-cycle op with RESULT=0, ZERO=1, DONE after the capture edge, BUSY stays 0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_FWD … OP_ROR, 3 bits);
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_MUL);
  - WIDTH default constant.
- One sub-module, alu_logic_unit: purely combinational FWD/ADD/AND/OR, WIDTH-parametrised, used by alu_seq for the single-cycle path.
- The FSM, shifter and multiplier stay in alu_seq.

Test Plan (WIDTH=8):
- ADD 200+100 → RESULT=44, ZERO=0, DONE one cycle after START, BUSY stays 0. FWD DATA2=0 → RESULT=0, ZERO=1.
- MUL 13×11 → RESULT=8'h8F on START edge + 8, BUSY high for 8 cycles. 16×16 → RESULT=0, ZERO=1.
- SHL 8'h03 by 3 → 8'h18 after 3 cycles. SHR 8'h80 by 7 → 8'h01 after 7. ROR 8'h81 by 1 → 8'hC0. SHL by 0 → 8'h03, single-cycle.
- Assert START mid-MUL with different operands → ignored, original product delivered. START in the DONE cycle → next op accepted, its DONE at the expected latency.
- Assert RESET at cycle 4 of a MUL → RESULT=0, ZERO=1, BUSY=0, no DONE. A following ADD 1+1 → RESULT=2.
- Build without ALU_MULT_EN, SELECT=100 with 5×5 → RESULT=0, ZERO=1, DONE after 1 cycle, BUSY never 1.
